// File: rtl/uart_rx.sv
// uart_rx: UART receive front end.
//   Oversamples the asynchronous serial line, deframes
//   start / 8 data (LSB first) / parity / stop, and presents the received byte.
//   Expected parity comes from a parity_checker instance: it is 1 when the
//   byte has an even number of ones, so that data plus parity bit is odd.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_rx          asynchronous serial line, idle high
//   o_data        last received byte
//   o_valid       one-cycle pulse when o_data / o_parity_err / o_frame_err update
//   o_parity_err  received parity bit differs from the expected odd-parity bit
//   o_frame_err   stop bit sampled low
//   o_busy        receiver is not in IDLE

// parity_checker: expected odd-parity bit for a byte
//   data     byte to check
//   odd_bit  1 when data holds an even number of ones
module parity_checker (
  input  logic [7:0] data,
  output logic       odd_bit
);
  assign odd_bit = ~^data;
endmodule

module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             rx_p0, rx_p1, rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic             exp_par;
  logic             shift_en, par_en, deliver;

  parity_checker u_parity (
    .data    (shift_q),
    .odd_bit (exp_par)
  );

  // stage p0/p1: two-flop synchronizer, idles high so reset looks like a quiet line
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // START waits half a bit so every later sample, taken a full bit apart,
  // lands in the middle of its bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CNT_W'(1);
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    deliver     = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          par_en      = 1'b1;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        // Leaving straight from the stop sample point keeps IDLE ready for a
        // start edge that immediately follows the stop bit.
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          deliver     = 1'b1;
          state_nxt   = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Data-only registers: always rewritten before they are consumed.
  always_ff @(posedge i_clk) begin
    if (shift_en) shift_q   <= {rx_s, shift_q[7:1]};
    if (par_en)   par_err_q <= rx_s ^ exp_par;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= 8'h00;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= deliver;
      if (deliver) begin
        o_data       <= shift_q;
        o_parity_err <= par_err_q;
        o_frame_err  <= ~rx_s;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (valid),
    .o_parity_err (perr),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } ev_t;

  ev_t got_q[$];
  int  cyc = 0;
  bit  busy_seen = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (valid) got_q.push_back('{data, perr, ferr, cyc});
  end

  // Reference: what a frame should deliver, from the framing rules alone.
  function automatic logic [9:0] model(input logic [7:0] b, input logic p, input logic s);
    logic want;
    want = (($countones(b) % 2) == 0);
    return {b, (p != want), ~s};
  endfunction

  function automatic logic good_par(input logic [7:0] b);
    return (($countones(b) % 2) == 0);
  endfunction

  function automatic ev_t ev_at(input int idx);
    ev_t e;
    e = '{8'hxx, 1'bx, 1'bx, -1};
    if (idx < got_q.size()) e = got_q[idx];
    return e;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic s, output int t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data, valid, perr, ferr, busy} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {data, valid, perr, ferr, busy});
    else n_pass++;
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if ({busy, got_q.size()} !== {1'b0, 32'd0})
      $display("FAIL reset_idle: busy=%b frames=%0d want 0/0", busy, got_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    int t0;
    ev_t e;
    got_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    e = ev_at(0);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL basic_count: got %0d want 1", got_q.size());
    else n_pass++;
    n_checks++;
    if ({e.d, e.pe, e.fe} !== model(8'hA5, 1'b1, 1'b1))
      $display("FAIL basic_frame: got %h want %h", {e.d, e.pe, e.fe}, model(8'hA5, 1'b1, 1'b1));
    else n_pass++;
    n_checks++;
    if ((e.cyc - t0) < 2 + CPB/2 + 10*CPB || (e.cyc - t0) > 2 + CPB/2 + 10*CPB + 2)
      $display("FAIL basic_latency: got %0d want %0d..%0d", e.cyc - t0,
               2 + CPB/2 + 10*CPB, 2 + CPB/2 + 10*CPB + 2);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_parity();
    int t0;
    ev_t e;
    got_q.delete();
    send_frame(8'h07, 1'b1, 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    e = ev_at(0);
    n_checks++;
    if ({e.d, e.pe, e.fe} !== {8'h07, 1'b1, 1'b0})
      $display("FAIL parity_err_frame: got %h want %h", {e.d, e.pe, e.fe}, {8'h07, 1'b1, 1'b0});
    else n_pass++;
    n_checks++;
    if (perr !== 1'b1) $display("FAIL parity_err_hold: got %b want 1", perr);
    else n_pass++;
    send_frame(8'h03, 1'b1, 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    e = ev_at(1);
    n_checks++;
    if ({e.d, e.pe, e.fe} !== model(8'h03, 1'b1, 1'b1))
      $display("FAIL parity_clear_frame: got %h want %h", {e.d, e.pe, e.fe}, model(8'h03, 1'b1, 1'b1));
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL parity_count: got %0d want 2", got_q.size());
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int t0;
    ev_t e;
    got_q.delete();
    send_frame(8'h3C, good_par(8'h3C), 1'b0, t0);
    repeat (20 * CPB) @(negedge clk);
    e = ev_at(0);
    n_checks++;
    if ({e.d, e.pe, e.fe} !== {8'h3C, 1'b0, 1'b1})
      $display("FAIL frame_err_frame: got %h want %h", {e.d, e.pe, e.fe}, {8'h3C, 1'b0, 1'b1});
    else n_pass++;
    n_checks++;
    if ({busy, got_q.size()} !== {1'b1, 32'd1})
      $display("FAIL frame_err_held_low: busy=%b frames=%0d want 1/1", busy, got_q.size());
    else n_pass++;
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if ({busy, ferr} !== 2'b01) $display("FAIL frame_err_release: busy/ferr=%b want 01", {busy, ferr});
    else n_pass++;
    send_frame(8'h5A, good_par(8'h5A), 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    e = ev_at(1);
    n_checks++;
    if ({e.d, e.pe, e.fe} !== {8'h5A, 1'b0, 1'b0})
      $display("FAIL frame_err_next: got %h want %h", {e.d, e.pe, e.fe}, {8'h5A, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_glitch();
    got_q.delete();
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (busy_seen !== 1'b1) $display("FAIL glitch_busy_pulse: got %b want 1", busy_seen);
    else n_pass++;
    n_checks++;
    if ({busy, got_q.size()} !== {1'b0, 32'd0})
      $display("FAIL glitch_rejected: busy=%b frames=%0d want 0/0", busy, got_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    ev_t e0, e1;
    got_q.delete();
    send_frame(8'h00, 1'b1, 1'b1, t0);
    send_frame(8'hFF, 1'b1, 1'b1, t1);
    repeat (2 * CPB) @(negedge clk);
    e0 = ev_at(0);
    e1 = ev_at(1);
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size());
    else n_pass++;
    n_checks++;
    if ({e0.d, e0.pe, e0.fe, e1.d, e1.pe, e1.fe} !== {model(8'h00, 1'b1, 1'b1), model(8'hFF, 1'b1, 1'b1)})
      $display("FAIL b2b_frames: got %h want %h", {e0.d, e0.pe, e0.fe, e1.d, e1.pe, e1.fe},
               {model(8'h00, 1'b1, 1'b1), model(8'hFF, 1'b1, 1'b1)});
    else n_pass++;
    n_checks++;
    if (e1.cyc - e0.cyc !== 11 * CPB)
      $display("FAIL b2b_spacing: got %0d want %0d", e1.cyc - e0.cyc, 11 * CPB);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    ev_t e;
    logic [7:0] b;
    got_q.delete();
    b = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({data, valid, perr, ferr, busy} !== 12'h000)
      $display("FAIL rst_mid_outputs: got %h want 000", {data, valid, perr, ferr, busy});
    else n_pass++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if ({busy, got_q.size()} !== {1'b0, 32'd0})
      $display("FAIL rst_mid_no_frame: busy=%b frames=%0d want 0/0", busy, got_q.size());
    else n_pass++;
    send_frame(8'h81, good_par(8'h81), 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    e = ev_at(0);
    n_checks++;
    if ({e.d, e.pe, e.fe} !== {8'h81, 1'b0, 1'b0})
      $display("FAIL rst_mid_next: got %h want %h", {e.d, e.pe, e.fe}, {8'h81, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [7:0] b;
    logic       p, s;
    int         t0, gap;
    ev_t        e;
    got_q.delete();
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      p = good_par(b) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      send_frame(b, p, s, t0);
      exp_q.push_back(model(b, p, s));
      if (!s) begin
        repeat ($urandom_range(1, 3) * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
      gap = $urandom_range(0, 2 * CPB);
      if (gap > 0) repeat (gap) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = ev_at(k);
      n_checks++;
      if ({e.d, e.pe, e.fe} !== exp_q[k])
        $display("FAIL rand_frame_%0d: got %h want %h", k, {e.d, e.pe, e.fe}, exp_q[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
